// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA plot path.
//   X_MAX / Y_MAX : last valid column / row of the 160x120 frame buffer
//   coord_x_t     : 8-bit x coordinate
//   coord_y_t     : 7-bit y coordinate
//   colour_t      : 3-bit RGB colour
//   count_t       : 15-bit saturating event counter
//   last_grant_e  : arbiter state, the client granted most recently
//   plot_dbg_t    : debug view of the arbiter/datapath for checkers
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam int X_MAX = 159;
   localparam int Y_MAX = 119;
   localparam int CNT_W = 15;

   typedef logic [7:0]       coord_x_t;
   typedef logic [6:0]       coord_y_t;
   typedef logic [2:0]       colour_t;
   typedef logic [CNT_W-1:0] count_t;

   localparam count_t COUNT_MAX = '1;

   typedef enum logic {
      LAST0 = 1'b0,
      LAST1 = 1'b1
   } last_grant_e;

   // Debug snapshot: current FSM state, whether a beat transfers this cycle
   // and whether that beat lies inside the visible frame.
   typedef struct packed {
      last_grant_e arb_state;
      logic        xfer;
      logic        in_range;
   } plot_dbg_t;

   // Increment that sticks at the counter's maximum instead of wrapping.
   function automatic count_t sat_inc(input count_t c);
      return (c == COUNT_MAX) ? c : c + count_t'(1);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-client round-robin grant logic with a 2-state FSM remembering which
// client transferred last. On a tie the other client wins, so two always-valid
// clients alternate strictly.
//
// Handshake: a beat transfers on a rising clk edge where cN_valid and
// cN_ready are both high. cN_ready is combinational from cN_valid and the
// FSM state, is never high without cN_valid, and at most one ready is high
// in any cycle. A lone valid client is always granted. Both readys are low
// while rst_n is low.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   c0_valid, c1_valid  : client requests
//   c0_ready, c1_ready  : grants (combinational)
//   state               : FSM state, exposed for debug
// -----------------------------------------------------------------------------
module rr_arb2
   import vga_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        c0_valid,
   input  logic        c1_valid,
   output logic        c0_ready,
   output logic        c1_ready,
   output last_grant_e state
);

   last_grant_e state_q;

   always_comb begin
      c0_ready = 1'b0;
      c1_ready = 1'b0;
      if (rst_n) begin
         c0_ready = c0_valid & (~c1_valid | (state_q == LAST1));
         c1_ready = c1_valid & (~c0_valid | (state_q == LAST0));
      end
   end

   // Reset into LAST1 so client 0 wins the first tie. A ready is only ever
   // high together with its valid, so ready alone marks a transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= LAST1;
      end else if (c0_ready) begin
         state_q <= LAST0;
      end else if (c1_ready) begin
         state_q <= LAST1;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/vga_plot_arbiter.sv
// -----------------------------------------------------------------------------
// vga_plot_arbiter
// Merges two pixel-plot clients onto one VGA adapter plot port. Grants come
// from rr_arb2; the granted beat is registered onto vga_x/vga_y/vga_colour
// with vga_plot high for exactly one cycle, one cycle after the transfer.
// Sustains one pixel per clock. Per-client forwarded-pixel counters saturate
// at 32767; clr zeroes every counter and wins over a same-cycle increment.
//
// Build option CLIP_EN: beats with x > X_MAX or y > Y_MAX are still accepted
// (and still move the arbiter) but are not plotted; they bump drop_count
// instead. Without CLIP_EN every beat is forwarded and drop_count is 0.
//
// Ports
//   clk, rst_n                  : clock, synchronous active-low reset
//   cN_valid/cN_x/cN_y/cN_colour: client N plot request
//   cN_ready                    : client N grant (valid/ready handshake)
//   vga_x/vga_y/vga_colour      : registered pixel to the adapter
//   vga_plot                    : one-cycle plot strobe
//   pix_count0/pix_count1       : pixels forwarded per client
//   drop_count                  : out-of-range beats discarded
//   clr                         : one-cycle counter clear
//   dbg                         : arbiter state and transfer flags
// -----------------------------------------------------------------------------
module vga_plot_arbiter
   import vga_pkg::*;
#(
   parameter int X_MAX = vga_pkg::X_MAX,
   parameter int Y_MAX = vga_pkg::Y_MAX
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        c0_valid,
   input  logic [7:0]  c0_x,
   input  logic [6:0]  c0_y,
   input  logic [2:0]  c0_colour,
   output logic        c0_ready,
   input  logic        c1_valid,
   input  logic [7:0]  c1_x,
   input  logic [6:0]  c1_y,
   input  logic [2:0]  c1_colour,
   output logic        c1_ready,
   output logic [7:0]  vga_x,
   output logic [6:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        vga_plot,
   output logic [14:0] pix_count0,
   output logic [14:0] pix_count1,
   output logic [14:0] drop_count,
   input  logic        clr,
   output plot_dbg_t   dbg
);

   localparam coord_x_t X_LIM = coord_x_t'(X_MAX);
   localparam coord_y_t Y_LIM = coord_y_t'(Y_MAX);

   last_grant_e arb_state;
   logic        c0_xfer;
   logic        c1_xfer;
   logic        xfer;
   logic        in_range;
   logic        keep;
   coord_x_t    sel_x;
   coord_y_t    sel_y;
   colour_t     sel_colour;
   count_t      pix0_q;
   count_t      pix1_q;

   rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .c0_valid (c0_valid),
      .c1_valid (c1_valid),
      .c0_ready (c0_ready),
      .c1_ready (c1_ready),
      .state    (arb_state)
   );

   assign c0_xfer = c0_valid & c0_ready;
   assign c1_xfer = c1_valid & c1_ready;
   assign xfer    = c0_xfer | c1_xfer;

   // At most one client transfers per cycle, so a 2:1 mux suffices.
   assign sel_x      = c1_xfer ? c1_x      : c0_x;
   assign sel_y      = c1_xfer ? c1_y      : c0_y;
   assign sel_colour = c1_xfer ? c1_colour : c0_colour;

   assign in_range = (sel_x <= X_LIM) && (sel_y <= Y_LIM);

`ifdef CLIP_EN
   assign keep = in_range;
`else
   assign keep = 1'b1;
`endif

   // Pixel register: strobe for one cycle per kept beat, hold coordinates
   // otherwise so the adapter inputs stay stable between plots.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vga_plot   <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
      end else begin
         vga_plot <= xfer & keep;
         if (xfer && keep) begin
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_colour;
         end
      end
   end

   // Forwarded-pixel counters; clr takes priority over the increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pix0_q <= '0;
         pix1_q <= '0;
      end else if (clr) begin
         pix0_q <= '0;
         pix1_q <= '0;
      end else begin
         if (c0_xfer && keep) begin
            pix0_q <= sat_inc(pix0_q);
         end
         if (c1_xfer && keep) begin
            pix1_q <= sat_inc(pix1_q);
         end
      end
   end

   assign pix_count0 = pix0_q;
   assign pix_count1 = pix1_q;

`ifdef CLIP_EN
   count_t drop_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_q <= '0;
      end else if (clr) begin
         drop_q <= '0;
      end else if (xfer && !in_range) begin
         drop_q <= sat_inc(drop_q);
      end
   end

   assign drop_count = drop_q;
`else
   assign drop_count = '0;
`endif

   assign dbg.arb_state = arb_state;
   assign dbg.xfer      = xfer;
   assign dbg.in_range  = in_range;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_plot_arbiter
// Self-checking bench for vga_plot_arbiter. A behavioural model tracks which
// client wins the next tie, the expected pixel stream (exp_q) and the
// counter values; every cycle the DUT's readys, pixel outputs and counters are
// compared against it. Build with +define+CLIP_EN to check the clipping build.
// -----------------------------------------------------------------------------
module tb_vga_plot_arbiter;
   import vga_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        c0_valid = 1'b0, c1_valid = 1'b0;
   logic [7:0]  c0_x = '0, c1_x = '0;
   logic [6:0]  c0_y = '0, c1_y = '0;
   logic [2:0]  c0_colour = '0, c1_colour = '0;
   logic        c0_ready, c1_ready;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;
   logic [14:0] pix_count0, pix_count1, drop_count;
   plot_dbg_t   dbg;

   always #5 clk = ~clk;

   vga_plot_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .c0_valid   (c0_valid),
      .c0_x       (c0_x),
      .c0_y       (c0_y),
      .c0_colour  (c0_colour),
      .c0_ready   (c0_ready),
      .c1_valid   (c1_valid),
      .c1_x       (c1_x),
      .c1_y       (c1_y),
      .c1_colour  (c1_colour),
      .c1_ready   (c1_ready),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .pix_count0 (pix_count0),
      .pix_count1 (pix_count1),
      .drop_count (drop_count),
      .clr        (clr),
      .dbg        (dbg)
   );

   // ---------------- scoreboard / model state ----------------
   int          n_cmp = 0;
   int          n_bad = 0;
   int          tie_winner = 0;   // client that wins the next tie
   int          m_pix0 = 0, m_pix1 = 0, m_drop = 0;
   logic [17:0] exp_q[$];         // {x, y, colour} of expected plots
   logic [17:0] last_pix = '0;    // what the adapter outputs should hold
   int          plot_cnt = 0;
   bit          cov_on = 1'b0;
   int          hits[160][120];

   typedef struct {
      logic v0;
      logic v1;
      logic r0;
      logic r1;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= 32767) ? 32767 : v + 1;
   endfunction

   function automatic bit in_window(input int x, input int y);
`ifdef CLIP_EN
      return (x <= 159) && (y <= 119);
`else
      return (x >= 0) && (y >= 0);
`endif
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v0, input logic [7:0] x0, input logic [6:0] y0,
                        input logic [2:0] k0, input logic v1, input logic [7:0] x1,
                        input logic [6:0] y1, input logic [2:0] k1);
      c0_valid = v0; c0_x = x0; c0_y = y0; c0_colour = k0;
      c1_valid = v1; c1_x = x1; c1_y = y1; c1_colour = k1;
   endtask

   // One clock: check readys before the edge, then everything registered.
   task automatic tick();
      logic g0, g1;
      bit   keep;
      logic [17:0] beat;
      #1;
      g0 = c0_valid && (!c1_valid || tie_winner == 0);
      g1 = c1_valid && (!c0_valid || tie_winner == 1);
      chk("c0_ready", c0_ready, g0);
      chk("c1_ready", c1_ready, g1);
      beat = g1 ? {c1_x, c1_y, c1_colour} : {c0_x, c0_y, c0_colour};
      keep = in_window(int'(beat[17:10]), int'(beat[9:3]));
      @(posedge clk);
      #1;
      if (g0) tie_winner = 1;
      else if (g1) tie_winner = 0;
      if (clr) begin
         m_pix0 = 0; m_pix1 = 0; m_drop = 0;
      end else if (g0 || g1) begin
         if (!keep) m_drop = sat(m_drop);
         else if (g0) m_pix0 = sat(m_pix0);
         else m_pix1 = sat(m_pix1);
      end
      if ((g0 || g1) && keep) exp_q.push_back(beat);
      chk("vga_plot", vga_plot, exp_q.size() != 0);
      if (exp_q.size() != 0) last_pix = exp_q.pop_front();
      chk("vga_x", vga_x, last_pix[17:10]);
      chk("vga_y", vga_y, last_pix[9:3]);
      chk("vga_colour", vga_colour, last_pix[2:0]);
      chk("pix_count0", pix_count0, m_pix0);
      chk("pix_count1", pix_count1, m_pix1);
      chk("drop_count", drop_count, m_drop);
      chk("arb_state", dbg.arb_state, (tie_winner == 0) ? int'(LAST1) : int'(LAST0));
      if (vga_plot) begin
         plot_cnt++;
         if (cov_on && vga_x < 160 && vga_y < 120) hits[vga_x][vga_y]++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_c0_ready", c0_ready, 0);
      chk("rst_c1_ready", c1_ready, 0);
      @(posedge clk);
      #1;
      tie_winner = 0; m_pix0 = 0; m_pix1 = 0; m_drop = 0;
      exp_q.delete();
      last_pix = '0;
      chk("rst_vga_plot", vga_plot, 0);
      chk("rst_vga_x", vga_x, 0);
      chk("rst_vga_y", vga_y, 0);
      chk("rst_vga_colour", vga_colour, 0);
      chk("rst_pix_count0", pix_count0, 0);
      chk("rst_pix_count1", pix_count1, 0);
      chk("rst_drop_count", drop_count, 0);
      chk("rst_state", dbg.arb_state, int'(LAST1));
      rst_n = 1'b1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int p0, bad;

      // {c0_valid, c1_valid} -> {c0_ready, c1_ready}, starting from reset.
      tbl[0]  = '{1, 1, 1, 0};
      tbl[1]  = '{1, 1, 0, 1};
      tbl[2]  = '{1, 0, 1, 0};
      tbl[3]  = '{1, 0, 1, 0};
      tbl[4]  = '{1, 1, 0, 1};
      tbl[5]  = '{0, 1, 0, 1};
      tbl[6]  = '{1, 1, 1, 0};
      tbl[7]  = '{0, 0, 0, 0};
      tbl[8]  = '{0, 1, 0, 1};
      tbl[9]  = '{0, 0, 0, 0};
      tbl[10] = '{1, 1, 1, 0};
      tbl[11] = '{1, 1, 0, 1};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].v0, 8'(i), 7'(i + 1), 3'(i), tbl[i].v1, 8'(i + 20), 7'(i + 3), 3'(i + 1));
         #1;
         chk("tbl_c0_ready", c0_ready, tbl[i].r0);
         chk("tbl_c1_ready", c1_ready, tbl[i].r1);
         tick();
      end

      // Single client plot with literal expectations.
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      drive(1, 8'd5, 7'd7, 3'd5, 0, 0, 0, 0);
      #1;
      chk("single_c0_ready", c0_ready, 1);
      tick();
      chk("single_plot", vga_plot, 1);
      chk("single_x", vga_x, 5);
      chk("single_y", vga_y, 7);
      chk("single_colour", vga_colour, 5);
      chk("single_pix0", pix_count0, 1);

      // Both valid for four cycles: c0, c1, c0, c1.
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      drive(1, 8'd1, 7'd1, 3'd1, 1, 8'd2, 7'd2, 3'd2);
      for (int i = 0; i < 4; i++) tick();
      chk("alt_pix0", pix_count0, 2);
      chk("alt_pix1", pix_count1, 2);

      // Out-of-range beats from client 1.
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      p0 = plot_cnt;
      drive(0, 0, 0, 0, 1, 8'd160, 7'd0, 3'd3);
      tick();
      drive(0, 0, 0, 0, 1, 8'd0, 7'd120, 3'd4);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
`ifdef CLIP_EN
      chk("clip_plots", plot_cnt - p0, 0);
      chk("clip_drop", drop_count, 2);
      chk("clip_pix1", pix_count1, 0);
`else
      chk("noclip_plots", plot_cnt - p0, 2);
      chk("noclip_drop", drop_count, 0);
      chk("noclip_pix1", pix_count1, 2);
`endif

      // Full frame, column-major, client 1 idle.
      do_reset();
      p0 = plot_cnt;
      cov_on = 1'b1;
      for (int x = 0; x < 160; x++) begin
         for (int y = 0; y < 120; y++) begin
            drive(1, 8'(x), 7'(y), 3'(x % 8), 0, 0, 0, 0);
            tick();
         end
      end
      cov_on = 1'b0;
      chk("frame_plots", plot_cnt - p0, 19200);
      chk("frame_pix0", pix_count0, 19200);
      bad = 0;
      for (int x = 0; x < 160; x++)
         for (int y = 0; y < 120; y++)
            if (hits[x][y] != 1) bad++;
      chk("frame_coverage_bad", bad, 0);

      // Keep streaming into saturation.
      for (int i = 0; i < 13570; i++) begin
         drive(1, 8'(i % 160), 7'((i / 160) % 120), 3'(i), 0, 0, 0, 0);
         tick();
      end
      chk("sat_pix0", pix_count0, 32767);

      // clr beats a same-cycle increment.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_pix0", pix_count0, 0);
      tick();
      chk("clr_after_pix0", pix_count0, 1);

      // Reset mid-stream with both clients valid.
      drive(1, 8'd10, 7'd11, 3'd2, 1, 8'd12, 7'd13, 3'd6);
      tick();
      tick();
      tick();
      do_reset();
      #1;
      chk("post_rst_c0_first", c0_ready, 1);
      chk("post_rst_c1_wait", c1_ready, 0);
      tick();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 175)), 7'($urandom_range(0, 127)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 175)),
               7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)));
         clr = ($urandom_range(0, 31) == 0);
         tick();
      end
      clr = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 SHALL have parameter X_MAX, default 159, last valid x column.
REQ-002 SHALL have parameter Y_MAX, default 119, last valid y row.
REQ-003 SHALL have port clk  input  1  system clock (CLOCK_50 domain), all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have ports c0_valid/c1_valid  input  1 each  client plot request.
REQ-006 SHALL have ports c0_x/c1_x  input  8 each  requested x.
REQ-007 SHALL have ports c0_y/c1_y  input  7 each  requested y.
REQ-008 SHALL have ports c0_colour/c1_colour  input  3 each  requested colour.
REQ-009 SHALL have ports c0_ready/c1_ready  output  1 each  grant; beat transfers when valid and ready are both high on a clock edge.
REQ-010 SHALL have ports vga_x  output  8, vga_y  output  7, vga_colour  output  3, vga_plot  output  1, to the VGA adapter.
REQ-011 SHALL have ports pix_count0/pix_count1  output  15 each  pixels forwarded per client.
REQ-012 SHALL have port drop_count  output  15  out-of-range beats discarded.
REQ-013 SHALL have port clr  input  1  one-cycle pulse zeroing all counters.

Function
REQ-014 SHALL grant at most one client per cycle; cN_ready combinational from cN_valid and FSM state.
REQ-015 SHALL implement 2-state FSM LAST0/LAST1 recording the most recently granted client.
REQ-016 SHALL, with one client valid, grant it regardless of state.
REQ-017 SHALL, with both valid, grant client 1 in LAST0 and client 0 in LAST1 (strict alternation).
REQ-018 SHALL move to LASTn only on a transfer by client n; otherwise hold state.
REQ-019 SHALL register each transfer: vga_plot=1 and vga_x/vga_y/vga_colour = beat fields exactly one cycle after the transfer edge.
REQ-020 SHALL drive vga_plot=0 on cycles following no transfer; vga_x/vga_y/vga_colour hold last values.
REQ-021 SHALL sustain one forwarded pixel per cycle (19200 back-to-back beats fill 160x120 in 19200 cycles + 1 latency).
REQ-022 SHALL increment pix_countN per forwarded beat, saturating at 32767.
REQ-023 SHALL give clr priority over a same-cycle increment (counter reads 0 next cycle).
REQ-024 SHALL never deassert cN_ready while cN_valid is high and no other client is valid.

Reset
REQ-025 SHALL on rst_n=0 at a clock edge set vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, all counters 0, state LAST1 (client 0 wins first tie).
REQ-026 SHALL drive c0_ready=c1_ready=0 while rst_n=0.
REQ-027 SHALL discard a beat transferred in the cycle reset asserts; no plot emitted after reset.

Configuration
REQ-028 SHALL, with CLIP_EN defined, accept (ready=1) but not forward beats with x>X_MAX or y>Y_MAX, increment drop_count (saturating) and not pix_countN, still update FSM state.
REQ-029 SHALL, without CLIP_EN, forward all beats unmodified and tie drop_count to 0.

Structure
REQ-030 SHALL take from shared package vga_pkg: X_MAX/Y_MAX constants, coord_x_t (8b), coord_y_t (7b), colour_t (3b), enum last_grant_e {LAST0, LAST1}.
REQ-031 SHALL place grant logic and FSM in sub-module rr_arb2; datapath register and counters in vga_plot_arbiter.

Verification
REQ-032 Reset then c0_valid only, x=5,y=7,colour=5 -> c0_ready=1 same cycle; next cycle vga_plot=1, vga_x=5, vga_y=7, vga_colour=5; pix_count0=1.
REQ-033 Both valid continuously after reset, 4 cycles -> grants c0,c1,c0,c1; pix_count0=pix_count1=2.
REQ-034 c0 streams full 160x120 column-major, colour=x%8, c1 idle -> 19200 consecutive plots, every pixel once, pix_count0=19200, finish within 19201 cycles.
REQ-035 CLIP_EN: c1 sends x=160,y=0 then x=0,y=120 -> both accepted, vga_plot stays 0, drop_count=2; without CLIP_EN -> two plots, drop_count=0.
REQ-036 rst_n low on a transfer cycle mid-stream -> next cycle vga_plot=0, counters 0; after release with both valid, client 0 granted first.
